pe_arbiter_4req: RTL and testbench
==================================

Name: pe_arbiter_4req

Overview:
- Sequential 4-requester arbiter that sequences access to a shared resource.
- Uses the same priority ordering as the team's 4-bit priority encoder: bit 3 highest, bit 0 lowest.
- Adds a registered one-hot/encoded grant, a grant-hold handshake, optional round-robin fairness and a hold timeout.
- Sits between the requesting units and the shared datapath; downstream logic consumes gnt_id as the mux select.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held (legal range 2..255); counter width = $clog2(MAX_HOLD+1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  arbiter enable; when low, no new grant is issued and any active grant is released.
- mode  input  1  0 = fixed priority, 1 = round robin; sampled only in IDLE.
- req  input  4  request vector, one bit per requester.
- done  input  1  single-cycle release pulse from the current owner.
- gnt  output  4  one-hot grant, registered.
- gnt_id  output  2  encoded index of the granted requester, registered.
- gnt_valid  output  1  high while any grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state = IDLE; gnt = 4'b0000; gnt_id = 2'b00; gnt_valid = 0; timeout = 0.
  - last = 2'b00; hold_cnt = 0.
  - Reset has priority over every other input, including mid-grant; the grant drops at that edge.
- States: IDLE, BUSY, GAP.
- IDLE:
  - If en && |req, the winner is selected and registered; next cycle state = BUSY, gnt/gnt_id/gnt_valid asserted, hold_cnt = 1.
  - Grant latency: one clock from the req sample to gnt visible.
  - If en=0 or req=0, stay in IDLE with outputs at 0.
- Winner selection:
  - mode=0: highest set index wins (3>2>1>0), identical to the priority-encoder truth table.
  - mode=1: search in descending order starting at (last-1) mod 4 and wrapping, e.g. last=2 gives order 1,0,3,2.
  - After reset, last=0 makes the round-robin order 3,2,1,0, which matches fixed priority.
- BUSY: the grant is held while all of the following are true:
  - en=1,
  - req[gnt_id]=1,
  - done=0,
  - hold_cnt < MAX_HOLD.
  - Each held cycle increments hold_cnt.
- Release from BUSY to GAP occurs on the first edge where any hold condition fails:
  - gnt, gnt_valid -> 0; gnt_id keeps its value; last <= gnt_id; hold_cnt <= 0.
  - If the cause is hold_cnt == MAX_HOLD (and none of done, req drop or en low is present), timeout = 1 for exactly the GAP cycle.
  - When done and expiry coincide, timeout = 0 (done has precedence).
- GAP:
  - Exactly one idle cycle with gnt=0, guaranteeing break-before-make between owners.
  - Then IDLE unconditionally; timeout returns to 0.
  - Minimum back-to-back grant spacing is therefore 2 cycles of gnt=0 (GAP + IDLE selection).
- Other rules:
  - A new request arriving while BUSY never pre-empts, regardless of priority.
  - A request that appears or drops during GAP is evaluated only in IDLE.
  - A mode change is honoured at the next IDLE evaluation; last is retained across mode changes.
  - done asserted while in IDLE or GAP is ignored.
  - Invariants, every cycle: gnt is one-hot or zero; gnt_valid == |gnt; when gnt_valid=1, gnt == (1 << gnt_id).

Test Plan:
- Reset and fixed priority:
  - Stimulus: rst_n=0 for 2 cycles, then rst_n=1, en=1, mode=0, req=4'b1010.
  - Required: 1 cycle later gnt=4'b1000, gnt_id=3, gnt_valid=1; with done pulsed after 3 cycles, next edge gnt=0, then GAP, IDLE, gnt=4'b0010.
- Enable gating:
  - Stimulus: en=0, req=4'b1111 for 5 cycles.
  - Required: gnt=0 throughout. Raising en gives gnt=4'b1000 one cycle later.
  - Dropping en while BUSY gives gnt=0 at the next edge, timeout=0.
- Round robin:
  - Stimulus: mode=1, req=4'b1111 held, done pulsed every grant.
  - Required grant sequence: 3,2,1,0,3; each grant separated by exactly 2 zero cycles.
- Timeout:
  - Stimulus: MAX_HOLD=16, req=4'b0100 held, done=0.
  - Required: gnt=4'b0100 for exactly 16 cycles, then timeout=1 for 1 cycle with gnt=0, then re-grant to requester 2.
- Request drop and no pre-emption:
  - Stimulus: grant to 1 (req=4'b0010), then raise req[3] while BUSY.
  - Required: gnt stays 4'b0010.
  - Then drop req[1]: at the next edge gnt=0, then GAP, IDLE; gnt=4'b1000.
- Reset mid-grant and coincident events:
  - Stimulus: rst_n=0 while gnt=4'b0100. Required: gnt=0 and gnt_valid=0 at that edge; after release, first grant follows mode=0 ordering.
  - Stimulus: done and expiry in the same cycle. Required: timeout stays 0.

Source files
------------

// File: rtl/pe_arbiter_4req_if.sv
// Handshake bundle between the requesting units and the 4-way arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface pe_arbiter_4req_if;
    logic       en;
    logic       mode;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en, mode, req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  en, mode, req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/pe_arbiter_4req.sv
// Sequential 4-requester arbiter: fixed-priority or round-robin selection,
// registered one-hot/encoded grant, done handshake, MAX_HOLD timeout and a one-cycle gap.
module pe_arbiter_4req #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pe_arbiter_4req_if.slave  bus
);
    localparam int unsigned CW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    gnt_id_q, gnt_id_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;

    logic [1:0]    start_s;
    logic [1:0]    win_s;
    logic          hold_ok_s;

    // Descending search that starts at 'start' and wraps; start itself ranks highest.
    function automatic logic [1:0] pick_winner(input logic [3:0] req, input logic [1:0] start);
        logic [1:0] idx;
        logic [1:0] win;
        win = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = start - 2'(i);
            if (req[idx]) begin
                win = idx;
            end else begin
                win = win;
            end
        end
        return win;
    endfunction

    // Winner selection; fixed priority is round robin anchored at index 3.
    always_comb begin
        start_s = 2'd3;
        if (bus.mode) begin
            start_s = last_q - 2'd1;
        end else begin
            start_s = 2'd3;
        end
        win_s = pick_winner(bus.req, start_s);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        hold_ok_s   = bus.en && bus.req[gnt_id_q] && !bus.done && (hold_cnt_q < CW'(MAX_HOLD));

        case (state_q)
            ST_IDLE: begin
                if (bus.en && (|bus.req)) begin
                    state_d     = ST_BUSY;
                    gnt_d       = 4'b0001 << win_s;
                    gnt_id_d    = win_s;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CW'(1);
                end else begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (hold_ok_s) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end else begin
                    state_d     = ST_GAP;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    last_d      = gnt_id_q;
                    hold_cnt_d  = '0;
                    // Only pure expiry flags a timeout; any owner-side release wins.
                    timeout_d   = bus.en && bus.req[gnt_id_q] && !bus.done;
                end
            end
            ST_GAP: begin
                state_d     = ST_IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'b00;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            last_q      <= 2'b00;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            last_q      <= last_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_pe_arbiter_4req.sv
// Directed self-checking bench for pe_arbiter_4req; expected values are hand-derived.
module tb_pe_arbiter_4req;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    pe_arbiter_4req_if bus();

    pe_arbiter_4req #(.MAX_HOLD(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v);
        chk({tag, ".gnt"}, 8'(bus.gnt), 8'(g));
        chk({tag, ".id"},  8'(bus.gnt_id), 8'(id));
        chk({tag, ".vld"}, 8'(bus.gnt_valid), 8'(v));
    endtask

    int exp_seq [5] = '{3, 2, 1, 0, 3};

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // Reset and fixed priority
        tick(); tick();
        chk_gnt("rst", 4'b0000, 2'd0, 1'b0);
        chk("rst.to", 8'(bus.timeout), 8'd0);
        rst_n = 1'b1; bus.en = 1'b1; bus.req = 4'b1010;
        tick();
        chk_gnt("fp1", 4'b1000, 2'd3, 1'b1);
        tick(); tick();
        chk("fp1.hold", 8'(bus.gnt), 8'h8);
        bus.done = 1'b1; bus.req = 4'b0010;
        tick();
        bus.done = 1'b0;
        chk("fp1.rel", 8'(bus.gnt), 8'h0);
        chk("fp1.to", 8'(bus.timeout), 8'd0);
        tick();
        chk("fp1.idle", 8'(bus.gnt), 8'h0);
        tick();
        chk_gnt("fp2", 4'b0010, 2'd1, 1'b1);
        bus.done = 1'b1; bus.req = 4'b0000;
        tick(); bus.done = 1'b0; tick();

        // Enable gating
        bus.en = 1'b0; bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("en0", 8'(bus.gnt), 8'h0);
        end
        bus.en = 1'b1;
        tick();
        chk_gnt("en1", 4'b1000, 2'd3, 1'b1);
        bus.en = 1'b0;
        tick();
        chk("endrop.gnt", 8'(bus.gnt), 8'h0);
        chk("endrop.to", 8'(bus.timeout), 8'd0);
        bus.req = 4'b0000;
        tick();

        // Round robin from a clean reset (last = 0)
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        bus.en = 1'b1; bus.mode = 1'b1; bus.req = 4'b1111;
        foreach (exp_seq[k]) begin
            tick();
            chk("rr.id", 8'(bus.gnt_id), 8'(exp_seq[k]));
            chk("rr.gnt", 8'(bus.gnt), 8'(4'b0001 << exp_seq[k]));
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            chk("rr.gap0", 8'(bus.gnt), 8'h0);
            tick();
            chk("rr.gap1", 8'(bus.gnt), 8'h0);
            if (k == 4) bus.req = 4'b0000;
        end
        bus.mode = 1'b0;

        // Timeout after 16 held cycles
        bus.req = 4'b0100;
        tick();
        chk_gnt("to.g", 4'b0100, 2'd2, 1'b1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to.hold", 8'(bus.gnt), 8'h4);
            chk("to.nto", 8'(bus.timeout), 8'd0);
        end
        tick();
        chk("to.rel", 8'(bus.gnt), 8'h0);
        chk("to.pulse", 8'(bus.timeout), 8'd1);
        tick();
        chk("to.idle", 8'(bus.gnt), 8'h0);
        chk("to.clr", 8'(bus.timeout), 8'd0);
        tick();
        chk_gnt("to.regnt", 4'b0100, 2'd2, 1'b1);

        // done coincident with expiry: no timeout
        for (int i = 1; i < 16; i++) tick();
        chk("co.hold16", 8'(bus.gnt), 8'h4);
        bus.done = 1'b1; bus.req = 4'b0000;
        tick();
        bus.done = 1'b0;
        chk("co.rel", 8'(bus.gnt), 8'h0);
        chk("co.to", 8'(bus.timeout), 8'd0);
        tick();

        // No pre-emption, then request drop
        bus.req = 4'b0010;
        tick();
        chk_gnt("np.g", 4'b0010, 2'd1, 1'b1);
        bus.req = 4'b1010;
        tick();
        chk("np.hold0", 8'(bus.gnt), 8'h2);
        tick();
        chk("np.hold1", 8'(bus.gnt), 8'h2);
        bus.req = 4'b1000;
        tick();
        chk("np.drop", 8'(bus.gnt), 8'h0);
        chk("np.to", 8'(bus.timeout), 8'd0);
        tick();
        chk("np.idle", 8'(bus.gnt), 8'h0);
        tick();
        chk_gnt("np.g3", 4'b1000, 2'd3, 1'b1);
        bus.done = 1'b1; bus.req = 4'b0000;
        tick(); bus.done = 1'b0; tick();

        // Reset mid-grant, then fixed-priority first grant
        bus.done = 1'b1;
        tick();
        chk("idle.done", 8'(bus.gnt), 8'h0);
        bus.done = 1'b0; bus.req = 4'b0100;
        tick();
        chk("rm.g", 8'(bus.gnt), 8'h4);
        rst_n = 1'b0;
        tick();
        chk_gnt("rm.rst", 4'b0000, 2'd0, 1'b0);
        rst_n = 1'b1; bus.req = 4'b0110;
        tick();
        chk_gnt("rm.first", 4'b0100, 2'd2, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
